// File: rtl/aig_tt_sim.sv
// Sequential truth-table simulator for small AND-inverter graphs.
// Evaluates one programmable AND node per cycle and reports the truth table of a chosen literal.
module aig_tt_sim #(
  parameter int NUM_IN    = 4,
  parameter int MAX_NODES = 16,
  localparam int TT_W     = 1 << NUM_IN,
  localparam int NVAR     = 1 + NUM_IN + MAX_NODES,
  localparam int LIT_W    = $clog2(2 * NVAR),
  localparam int IDX_W    = $clog2(MAX_NODES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [LIT_W-1:0] cfg_lit0,
  input  logic [LIT_W-1:0] cfg_lit1,
  input  logic [IDX_W:0]   num_nodes,
  input  logic [LIT_W-1:0] out_lit,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [TT_W-1:0]  tt_out
);

  localparam int VAR_W = LIT_W - 1;

  // Handshake: start is taken only in IDLE; done is a one-cycle pulse in FIN, with
  // tt_out/err valid in that cycle and held until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [LIT_W-1:0] lit0_tab [MAX_NODES];
  logic [LIT_W-1:0] lit1_tab [MAX_NODES];
  logic [TT_W-1:0]  val_rf   [MAX_NODES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   nn_q;
  logic [LIT_W-1:0] out_lit_q;

  logic [LIT_W-1:0] cur_l0;
  logic [LIT_W-1:0] cur_l1;
  logic [VAR_W-1:0] node_var;
  logic [VAR_W-1:0] out_var_q;
  logic [VAR_W-1:0] in_out_var;
  logic             fwd_err;
  logic             last_node;
  logic             out_err_q;
  logic             out_err_in;
  logic             nn_bad;
  logic             nn_zero;
  logic             addr_ok;
  logic [TT_W-1:0]  and_res;
  logic [TT_W-1:0]  fin_vec;
  logic [TT_W-1:0]  in_vec;

  // Projection vector of input k: bit m is bit k of the minterm index m.
  function automatic logic [TT_W-1:0] proj_vec(input int k);
    logic [TT_W-1:0] r;
    for (int m = 0; m < TT_W; m++) begin
      r[m] = 1'((m >> k) & 1);
    end
    return r;
  endfunction

  // Truth table of a literal; unknown variables read as constant 0.
  function automatic logic [TT_W-1:0] lit_vec(input logic [LIT_W-1:0] lit);
    logic [VAR_W-1:0] v;
    logic [TT_W-1:0]  r;
    v = lit[LIT_W-1:1];
    r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (v == VAR_W'(k + 1)) r = proj_vec(k);
    end
    for (int k = 0; k < MAX_NODES; k++) begin
      if (v == VAR_W'(NUM_IN + 1 + k)) r = val_rf[k];
    end
    return r ^ {TT_W{lit[0]}};
  endfunction

  always_comb begin
    cur_l0     = lit0_tab[idx];
    cur_l1     = lit1_tab[idx];
    node_var   = VAR_W'(NUM_IN + 1) + VAR_W'(idx);
    fwd_err    = (cur_l0[LIT_W-1:1] >= node_var) || (cur_l1[LIT_W-1:1] >= node_var);
    and_res    = lit_vec(cur_l0) & lit_vec(cur_l1);
    last_node  = ({1'b0, idx} == (nn_q - 1'b1));
    out_var_q  = out_lit_q[LIT_W-1:1];
    out_err_q  = int'(out_var_q) > (NUM_IN + int'(nn_q));
    // The last node's value is not yet in val_rf when FIN is entered, so forward it.
    fin_vec    = (out_var_q == node_var) ? (and_res ^ {TT_W{out_lit_q[0]}}) : lit_vec(out_lit_q);
    in_out_var = out_lit[LIT_W-1:1];
    nn_zero    = (num_nodes == '0);
    nn_bad     = num_nodes > (IDX_W + 1)'(MAX_NODES);
    out_err_in = int'(in_out_var) > (NUM_IN + int'(num_nodes));
    in_vec     = lit_vec(out_lit);
    addr_ok    = {1'b0, cfg_addr} < (IDX_W + 1)'(MAX_NODES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tt_out    <= '0;
      idx       <= '0;
      nn_q      <= '0;
      out_lit_q <= '0;
      for (int k = 0; k < MAX_NODES; k++) begin
        lit0_tab[k] <= '0;
        lit1_tab[k] <= '0;
        val_rf[k]   <= '0;
      end
    end else begin
      // Table writes are dropped during EVAL so a run always sees a stable table.
      if (cfg_we && (state != EVAL) && addr_ok) begin
        lit0_tab[cfg_addr] <= cfg_lit0;
        lit1_tab[cfg_addr] <= cfg_lit1;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            nn_q      <= num_nodes;
            out_lit_q <= out_lit;
            idx       <= '0;
            if (nn_zero || nn_bad) begin
              state  <= FIN;
              done   <= 1'b1;
              err    <= nn_bad || out_err_in;
              tt_out <= (nn_bad || out_err_in) ? '0 : in_vec;
            end else begin
              state <= EVAL;
              busy  <= 1'b1;
              err   <= 1'b0;
            end
          end
        end

        EVAL: begin
          if (fwd_err) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
            tt_out <= '0;
          end else begin
            val_rf[idx] <= and_res;
            if (last_node) begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              err    <= out_err_q;
              tt_out <= out_err_q ? '0 : fin_vec;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aig_tt_sim.sv
// Directed bench for aig_tt_sim: expected truth table, err and latency are queued at start
// and compared when done pulses.
module tb_aig_tt_sim;

  localparam int TT_W  = 16;
  localparam int LIT_W = 6;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [LIT_W-1:0] cfg_lit0;
  logic [LIT_W-1:0] cfg_lit1;
  logic [IDX_W:0]   num_nodes;
  logic [LIT_W-1:0] out_lit;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [TT_W-1:0]  tt_out;

  int checks = 0;
  int errors = 0;

  logic [TT_W-1:0] exp_q[$];
  logic            exp_err_q[$];
  int              exp_lat_q[$];

  aig_tt_sim #(.NUM_IN(4), .MAX_NODES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_lit0  (cfg_lit0),
    .cfg_lit1  (cfg_lit1),
    .num_nodes (num_nodes),
    .out_lit   (out_lit),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tt_out    (tt_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_node(input int addr, input int l0, input int l1);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(addr);
    cfg_lit0 = LIT_W'(l0);
    cfg_lit1 = LIT_W'(l1);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic start_run(input int nn, input int ol, input logic [TT_W-1:0] e_tt,
                           input logic e_err, input int e_lat);
    @(negedge clk);
    num_nodes = (IDX_W + 1)'(nn);
    out_lit   = LIT_W'(ol);
    start     = 1'b1;
    exp_q.push_back(e_tt);
    exp_err_q.push_back(e_err);
    exp_lat_q.push_back(e_lat);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded), compares against the scoreboard, then checks the pulse ends.
  // inject: cycle at which start and a node-0 write are attempted mid-run (0 = none).
  // poke_fin: also assert start during the done cycle.
  task automatic wait_done(input string tag, input int inject, input bit poke_fin);
    int cyc;
    logic [TT_W-1:0] e_tt;
    logic e_err;
    int e_lat;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 1 && exp_lat_q.size() > 0 && exp_lat_q[0] > 1)
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
      if (cyc == inject) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_lit0 = '0;
        cfg_lit1 = '0;
      end
      @(posedge clk);
      #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      cyc++;
    end
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e_tt  = exp_q.pop_front();
      e_err = exp_err_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
      check({tag, "_tt"}, 32'(tt_out), 32'(e_tt));
      check({tag, "_err"}, 32'(err), 32'(e_err));
      check({tag, "_busy_fin"}, 32'(busy), 32'd0);
    end
    if (poke_fin) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run(input string tag, input int nn, input int ol,
                     input logic [TT_W-1:0] e_tt, input logic e_err, input int e_lat);
    start_run(nn, ol, e_tt, e_err, e_lat);
    wait_done(tag, 0, 1'b0);
  endtask

  initial begin
    int extra_done;
    int extra_busy;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_lit0  = '0;
    cfg_lit1  = '0;
    num_nodes = '0;
    out_lit   = '0;
    start     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tt", 32'(tt_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single AND x0 & x1 and its complement
    write_node(0, 2, 4);
    run("and", 1, 10, 16'h8888, 1'b0, 2);
    run("nand", 1, 11, 16'h7777, 1'b0, 2);
    run("out_range", 1, 12, 16'h0000, 1'b1, 2);

    // XOR from three ANDs
    write_node(0, 2, 5);
    write_node(1, 3, 4);
    write_node(2, 11, 13);
    run("xor", 3, 15, 16'h6666, 1'b0, 4);
    run("xnor", 3, 14, 16'h9999, 1'b0, 4);

    // Zero-node runs and an oversized node count
    run("const0", 0, 0, 16'h0000, 1'b0, 1);
    run("const1", 0, 1, 16'hFFFF, 1'b0, 1);
    run("x3", 0, 8, 16'hFF00, 1'b0, 1);
    run("nn0_out_range", 0, 10, 16'h0000, 1'b1, 1);
    run("nn_big", 17, 10, 16'h0000, 1'b1, 1);

    // Forward reference
    write_node(0, 2, 12);
    run("fwd_ref", 2, 15, 16'h0000, 1'b1, 2);

    // Write and start in the same idle cycle: the run sees the new node 0
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = '0;
    cfg_lit0  = LIT_W'(2);
    cfg_lit1  = LIT_W'(5);
    num_nodes = (IDX_W + 1)'(3);
    out_lit   = LIT_W'(15);
    start     = 1'b1;
    exp_q.push_back(16'h6666);
    exp_err_q.push_back(1'b0);
    exp_lat_q.push_back(4);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    wait_done("we_start", 0, 1'b0);

    // Start and write mid-run, plus start in the done cycle: all ignored
    start_run(3, 15, 16'h6666, 1'b0, 4);
    wait_done("busy_prot", 2, 1'b1);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    check("busy_prot_extra_done", 32'(extra_done), 32'd0);
    check("busy_prot_extra_busy", 32'(extra_busy), 32'd0);
    run("busy_prot_table", 3, 15, 16'h6666, 1'b0, 4);

    // Reset in the middle of EVAL
    start_run(3, 14, 16'h9999, 1'b0, 4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_tt", 32'(tt_out), 32'd0);
    exp_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    @(negedge clk) rst_n = 1'b1;

    // Table cleared by reset: node 0 is now 0 & 0
    run("post_rst", 1, 10, 16'h0000, 1'b0, 2);
    run("post_rst_x2", 1, 6, 16'hF0F0, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
